// File: rtl/sensor_scan_manager_if.sv
// Status/handshake bundle between the matrix scanner and the board consumer.
// master drives the debounced board and change mask; slave returns the ack pulse.
interface sensor_scan_manager_if #(
   parameter int ROWS = 8,
   parameter int COLS = 4
);
   logic [ROWS*COLS-1:0] board;
   logic                 board_valid;
   logic [ROWS*COLS-1:0] changed;
   logic                 change_pending;
   logic                 scan_done;
   logic                 ack;

   modport master (
      output board, board_valid, changed, change_pending, scan_done,
      input  ack
   );

   modport slave (
      input  board, board_valid, changed, change_pending, scan_done,
      output ack
   );
endinterface

// File: rtl/sensor_scan_manager.sv
// Row-by-row reed-switch matrix scanner with multi-scan debounce,
// a stable occupancy bitmap and a sticky, ack-cleared change mask.
module sensor_scan_manager #(
   parameter int ROWS     = 8,
   parameter int COLS     = 4,
   parameter int SETTLE   = 16,
   parameter int DEBOUNCE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ROWS-1:0]       row_sel,
   input  logic [COLS-1:0]       col_in,
   sensor_scan_manager_if.master status
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(SETTLE);
   localparam int STB_W = $clog2(DEBOUNCE + 1);
   localparam int BITS  = ROWS * COLS;

   typedef enum logic [1:0] {IDLE, SELECT, SAMPLE, COMPARE} state_t;

   state_t            state_reg, state_next;
   logic [ROW_W-1:0]  row_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [COLS-1:0]   col_meta_reg, col_sync_reg;
   logic [BITS-1:0]   scan_buf_reg, prev_scan_reg;
   logic [STB_W-1:0]  stable_cnt_reg, stable_next;
   logic [BITS-1:0]   board_reg, changed_reg, delta;
   logic              board_valid_reg;
   logic              commit;
   logic              row_drive;
   logic              last_settle, last_row;

   assign last_settle = (cnt_reg == CNT_W'(SETTLE - 1));
   assign last_row    = (row_reg == ROW_W'(ROWS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable) state_next = SELECT;
         SELECT:  if (last_settle) state_next = SAMPLE;
         SAMPLE:  state_next = last_row ? COMPARE : SELECT;
         COMPARE: state_next = enable ? SELECT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      row_drive        = (state_reg == SELECT) || (state_reg == SAMPLE);
      status.scan_done = (state_reg == COMPARE);
   end

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         assign row_sel[gi] = row_drive && (row_reg == ROW_W'(gi));
      end
   endgenerate

   // Debounce bookkeeping: the count saturates so a steady board never recommits
   always_comb begin
      stable_next = STB_W'(1);
      if (scan_buf_reg == prev_scan_reg) begin
         if (stable_cnt_reg < STB_W'(DEBOUNCE)) stable_next = stable_cnt_reg + 1'b1;
         else                                   stable_next = stable_cnt_reg;
      end
      delta  = board_reg ^ scan_buf_reg;
      commit = (state_reg == COMPARE) && (stable_next == STB_W'(DEBOUNCE)) &&
               ((scan_buf_reg != board_reg) || !board_valid_reg);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         col_meta_reg    <= '0;
         col_sync_reg    <= '0;
         row_reg         <= '0;
         cnt_reg         <= '0;
         scan_buf_reg    <= '0;
         prev_scan_reg   <= '0;
         stable_cnt_reg  <= '0;
         board_reg       <= '0;
         board_valid_reg <= 1'b0;
         changed_reg     <= '0;
      end else begin
         col_meta_reg <= col_in;
         col_sync_reg <= col_meta_reg;

         case (state_reg)
            IDLE: begin
               row_reg <= '0;
               cnt_reg <= '0;
            end
            SELECT: begin
               cnt_reg <= last_settle ? '0 : cnt_reg + 1'b1;
            end
            SAMPLE: begin
               scan_buf_reg[row_reg*COLS +: COLS] <= col_sync_reg;
               if (!last_row) row_reg <= row_reg + 1'b1;
            end
            COMPARE: begin
               row_reg        <= '0;
               cnt_reg        <= '0;
               stable_cnt_reg <= stable_next;
               prev_scan_reg  <= scan_buf_reg;
            end
            default: ;
         endcase

         if (commit) begin
            board_reg       <= scan_buf_reg;
            board_valid_reg <= 1'b1;
         end

         // A same-cycle ack only discards history, never the bits this commit flips
         if (status.ack && commit) changed_reg <= delta;
         else if (status.ack)      changed_reg <= '0;
         else if (commit)          changed_reg <= changed_reg | delta;
      end
   end

   assign status.board          = board_reg;
   assign status.board_valid    = board_valid_reg;
   assign status.changed        = changed_reg;
   assign status.change_pending = |changed_reg;
endmodule

// File: tb/tb_sensor_scan_manager.sv
// Scan-level bench: a table of per-scan matrix patterns with expected board state,
// plus hand sequences for reset, timing, enable drop and mid-scan reset.
module tb_sensor_scan_manager;
   localparam int ROWS = 8;
   localparam int COLS = 4;

   typedef struct {
      logic [31:0] m;
      logic        ack;
      logic [31:0] board;
      logic        valid;
      logic [31:0] changed;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic            ack = 1'b0;
   logic [ROWS-1:0] row_sel;
   logic [COLS-1:0] col_in;
   logic [31:0]     mtx = 32'h0;

   int   checks = 0;
   int   errors = 0;
   int   scan_no = 0;
   vec_t sb_q[$];
   vec_t tbl[14];

   sensor_scan_manager_if #(.ROWS(ROWS), .COLS(COLS)) sif();

   sensor_scan_manager #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE(4), .DEBOUNCE(3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .row_sel (row_sel),
      .col_in  (col_in),
      .status  (sif.master)
   );

   assign sif.ack = ack;

   always #5 clk = ~clk;

   // Matrix model: the selected row presents its nibble of mtx, nothing otherwise
   always_comb begin
      col_in = '0;
      for (int r = 0; r < ROWS; r++)
         if (row_sel[r]) col_in = mtx[r*COLS +: COLS];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] b, input logic v,
                                input logic [31:0] ch);
      check({tag, "_board"},   sif.board, b);
      check({tag, "_valid"},   32'(sif.board_valid), 32'(v));
      check({tag, "_changed"}, sif.changed, ch);
      check({tag, "_pending"}, 32'(sif.change_pending), 32'(|ch));
   endtask

   // Drive one scan's matrix, wait for its scan_done, then compare the committed state
   task automatic run_scan(input vec_t v);
      vec_t e;
      int   n;
      mtx = v.m;
      sb_q.push_back(v);
      n = 0;
      @(negedge clk);
      while (!sif.scan_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      e = sb_q.pop_front();
      scan_no++;
      if (!sif.scan_done) begin
         check("scan_done_timeout", 32'(sif.scan_done), 32'd1);
         return;
      end
      ack = e.ack;
      @(posedge clk);
      #1;
      ack = 1'b0;
      $display("scan %0d m=%h ack=%0b board=%h valid=%0b changed=%h", scan_no, e.m, e.ack,
               sif.board, sif.board_valid, sif.changed);
      check_outputs($sformatf("scan%0d", scan_no), e.board, e.valid, e.changed);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_row_sel", 32'(row_sel), 32'h0);
      check("rst_scan_done", 32'(sif.scan_done), 32'h0);
      check_outputs("rst", 32'h0, 1'b0, 32'h0);
      reset = 1'b1;
   endtask

   initial begin
      int  c;
      int  dones;
      bit  saw_last;

      // Per-scan table, DEBOUNCE=3
      tbl[0]  = '{32'h000000F1, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
      tbl[1]  = '{32'h000000F1, 1'b0, 32'h00000000, 1'b0, 32'h00000000};
      tbl[2]  = '{32'h000000F1, 1'b0, 32'h000000F1, 1'b1, 32'h000000F1};
      tbl[3]  = '{32'h000000F1, 1'b1, 32'h000000F1, 1'b1, 32'h00000000};
      tbl[4]  = '{32'h000000D1, 1'b0, 32'h000000F1, 1'b1, 32'h00000000};
      tbl[5]  = '{32'h000000F1, 1'b0, 32'h000000F1, 1'b1, 32'h00000000};
      tbl[6]  = '{32'h000000D1, 1'b0, 32'h000000F1, 1'b1, 32'h00000000};
      tbl[7]  = '{32'h000000D1, 1'b0, 32'h000000F1, 1'b1, 32'h00000000};
      tbl[8]  = '{32'h000000D1, 1'b0, 32'h000000D1, 1'b1, 32'h00000020};
      tbl[9]  = '{32'h000000D1, 1'b0, 32'h000000D1, 1'b1, 32'h00000020};
      tbl[10] = '{32'h800000D1, 1'b0, 32'h000000D1, 1'b1, 32'h00000020};
      tbl[11] = '{32'h800000D1, 1'b0, 32'h000000D1, 1'b1, 32'h00000020};
      tbl[12] = '{32'h800000D1, 1'b1, 32'h800000D1, 1'b1, 32'h80000000};
      tbl[13] = '{32'h800000D1, 1'b1, 32'h800000D1, 1'b1, 32'h00000000};

      // Reset and first-scan timing with an empty matrix
      enable = 1'b1;
      mtx = 32'h0;
      do_reset();
      c = 1;
      @(negedge clk);
      while (row_sel == '0 && c < 10) begin
         @(negedge clk);
         c++;
      end
      check("first_row_c1", 32'(row_sel), 32'h01);
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("first_row_c%0d", k), 32'(row_sel), 32'h01);
      end
      c = 4;
      while (!sif.scan_done && c < 100) begin
         @(negedge clk);
         c++;
         if (c == 6) check("row1_sel", 32'(row_sel), 32'h02);
      end
      check("first_done_cycle", 32'(c), 32'd41);
      $display("timing first scan_done at cycle %0d", c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!sif.scan_done && c < 100);
      check("scan_period", 32'(c), 32'd41);
      $display("timing scan period %0d", c);
      @(posedge clk);
      #1;
      check_outputs("empty2", 32'h0, 1'b0, 32'h0);
      // Third identical empty scan: commit with zero delta
      run_scan('{32'h0, 1'b0, 32'h0, 1'b1, 32'h0});

      // Table-driven debounce, bounce, ack and ack-collision vectors
      do_reset();
      scan_no = 0;
      for (int i = 0; i < 14; i++) run_scan(tbl[i]);

      // Enable drop during row 3
      c = 0;
      @(negedge clk);
      while (row_sel != 8'h08 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("reach_row3", 32'(row_sel), 32'h08);
      enable = 1'b0;
      saw_last = 1'b0;
      dones = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (row_sel == 8'h80) saw_last = 1'b1;
         if (sif.scan_done) dones++;
      end
      $display("enable drop: saw_row7=%0b scan_done=%0d row_sel=%h", saw_last, dones, row_sel);
      check("drop_finish_rows", 32'(saw_last), 32'd1);
      check("drop_done_count", 32'(dones), 32'd1);
      check("drop_idle_row_sel", 32'(row_sel), 32'h0);
      check_outputs("drop", 32'h800000D1, 1'b1, 32'h0);

      // Reset one scan before a pending commit
      @(posedge clk);
      #1;
      enable = 1'b1;
      run_scan('{32'h12345678, 1'b0, 32'h800000D1, 1'b1, 32'h0});
      run_scan('{32'h12345678, 1'b0, 32'h800000D1, 1'b1, 32'h0});
      c = 0;
      @(negedge clk);
      while (row_sel != 8'h40 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("reach_row6", 32'(row_sel), 32'h40);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      $display("mid-scan reset: board=%h valid=%0b changed=%h", sif.board, sif.board_valid,
               sif.changed);
      check("midrst_row_sel", 32'(row_sel), 32'h0);
      check_outputs("midrst", 32'h0, 1'b0, 32'h0);
      run_scan('{32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0});
      run_scan('{32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0});
      run_scan('{32'h12345678, 1'b0, 32'h12345678, 1'b1, 32'h12345678});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
